// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle register-to-register execute unit.
// Register file, ALU and a four-state control FSM (IDLE -> RD -> EX -> WB).
// One instruction is accepted over a valid/ready handshake in IDLE. Its
// operands are read in RD and the ALU output is staged in EX. The result is
// written back in WB, with a one-cycle done pulse.
// Optional build macro: EXEC_SEQ_SATURATE_EN. When it is defined, ADD and SUB
// saturate as unsigned values. When it is undefined, ADD and SUB wrap.
module exec_sequencer #(
  parameter int DATA_W     = 12,
  parameter int REG_ADDR_W = 3,
  parameter int OP_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  zero_flag,
  output logic                  carry_flag,
  input  logic                  dbg_we,
  input  logic [REG_ADDR_W-1:0] dbg_waddr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [REG_ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0]     dbg_rdata
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [REG_ADDR_W-1:0]   rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]       opa_q, opa_d;
  logic [DATA_W-1:0]       opb_q, opb_d;
  logic [DATA_W-1:0]       alu_q, alu_d;
  logic                    zstg_q, zstg_d;
  logic                    cstg_q, cstg_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    carry_q, carry_d;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];

  logic                    accept;
  logic [DATA_W:0]         sum;
  logic [DATA_W:0]         diff;
  logic [DATA_W-1:0]       alu_val;
  logic                    carry_val;

  // Handshake: ready only in IDLE, outside reset, and when no debug write is pending.
  always_comb begin
    in_ready = (state_q == S_IDLE) && !dbg_we && !rst;
    accept   = in_valid && in_ready;
  end

  // Next-state logic for the control FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RD;
      S_RD:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the instruction fields on accept and the operands in RD.
  always_comb begin
    op_d  = op_q;
    rd_d  = rd_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    opa_d = opa_q;
    opb_d = opb_q;
    if (accept) begin
      op_d  = in_opcode;
      rd_d  = in_rd;
      rs1_d = in_rs1;
      rs2_d = in_rs2;
    end
    if (state_q == S_RD) begin
      opa_d = regs_q[rs1_q];
      opb_d = regs_q[rs2_q];
    end
  end

  // ALU: combinational result and carry/borrow from the latched operands.
  always_comb begin
    sum       = {1'b0, opa_q} + {1'b0, opb_q};
    diff      = {1'b0, opa_q} - {1'b0, opb_q};
    alu_val   = '0;
    carry_val = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        carry_val = sum[DATA_W];
`ifdef EXEC_SEQ_SATURATE_EN
        alu_val   = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        alu_val   = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        carry_val = diff[DATA_W];
`ifdef EXEC_SEQ_SATURATE_EN
        alu_val   = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        alu_val   = diff[DATA_W-1:0];
`endif
      end
      OP_AND:  alu_val = opa_q & opb_q;
      OP_OR:   alu_val = opa_q | opb_q;
      OP_XOR:  alu_val = opa_q ^ opb_q;
      OP_SLT:  alu_val = ($signed(opa_q) < $signed(opb_q)) ? DATA_W'(1) : '0;
      OP_MOV:  alu_val = opa_q;
      default: alu_val = '0;
    endcase
  end

  // EX staging and WB commit of the register file, result and flags. Debug writes land in IDLE.
  always_comb begin
    alu_d    = alu_q;
    zstg_d   = zstg_q;
    cstg_d   = cstg_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    regs_d   = regs_q;
    if (state_q == S_EX) begin
      alu_d  = alu_val;
      zstg_d = (alu_val == '0);
      cstg_d = carry_val;
    end
    if ((state_q == S_WB) && (op_q != OP_NOP)) begin
      regs_d[rd_q] = alu_q;
      result_d     = alu_q;
      zero_d       = zstg_q;
      carry_d      = cstg_q;
    end
    if ((state_q == S_IDLE) && dbg_we) begin
      regs_d[dbg_waddr] = dbg_wdata;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      alu_q    <= '0;
      zstg_q   <= 1'b0;
      cstg_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      // NOTE: the register file must read zero after reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      alu_q    <= alu_d;
      zstg_q   <= zstg_d;
      cstg_q   <= cstg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Output drive: done marks the WB cycle; the debug read port is combinational.
  always_comb begin
    done       = (state_q == S_WB);
    result     = result_q;
    zero_flag  = zero_q;
    carry_flag = carry_q;
    dbg_rdata  = regs_q[dbg_raddr];
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Parametrised multi-cycle execute unit: register file, ALU and control FSM in one block.
- Accepts one register-to-register instruction (opcode, rd, rs1, rs2) over a valid/ready handshake. It reads operands, executes, writes back, then reports completion.
- Successor to the fixed 12-bit/8-register datapath. Adds generic widths, an FSM, flags, handshake and debug access.

Parameters:
- DATA_W, 12, register and ALU data width in bits (>=4)
- REG_ADDR_W, 3, register address width; register count = 2**REG_ADDR_W
- OP_W, 3, opcode width; fixed at 3, other values unsupported

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept an instruction
- in_opcode  in  OP_W  operation
- in_rd  in  REG_ADDR_W  destination register
- in_rs1  in  REG_ADDR_W  source register 1
- in_rs2  in  REG_ADDR_W  source register 2
- done  out  1  one-cycle pulse at writeback
- result  out  DATA_W  last ALU result, registered
- zero_flag  out  1  last result == 0
- carry_flag  out  1  carry/borrow of last ADD/SUB
- dbg_we  in  1  debug register write
- dbg_waddr  in  REG_ADDR_W  debug write address
- dbg_wdata  in  DATA_W  debug write data
- dbg_raddr  in  REG_ADDR_W  debug read address
- dbg_rdata  out  DATA_W  combinational register read

Behaviour:
- Reset (rst=1 at clk edge):
  - All registers, result, flags and done go to 0.
  - State goes to IDLE.
  - in_ready is 0 while rst is high.
  - Reset mid-instruction aborts it: no writeback, no done.
- FSM states: IDLE -> RD -> EX -> WB -> IDLE.
  - IDLE: in_ready = !dbg_we. Handshake (in_valid & in_ready) latches opcode/rd/rs1/rs2 and goes to RD.
  - RD: latch regs[rs1] and regs[rs2] into operand registers.
  - EX: compute the ALU output and next flags into staging registers.
  - WB: write regs[rd] (unless NOP), update result and flags, assert done for this cycle only, return to IDLE.
- Latency and throughput:
  - Accept at cycle N; done high in cycle N+3; new register value visible on dbg_rdata from cycle N+4.
  - in_ready is low in RD/EX/WB.
  - Maximum throughput is 1 instruction per 4 cycles.
  - Back-to-back dependent instructions need no hazard logic.
- Opcodes (all arithmetic modulo 2**DATA_W):
  - 000 NOP: no writeback; result and flags unchanged; done still pulses.
  - 001 ADD: rs1+rs2; carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - 010 SUB: rs1-rs2; carry = borrow (1 iff rs1 < rs2, unsigned).
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SLT: 1 if rs1 < rs2 (signed two's complement), else 0.
  - 111 MOV: rs1 copied to rd.
  - Ops 011-111 clear carry.
- zero_flag is updated for every non-NOP op.
- rd may equal rs1/rs2: operands are read in RD, before the WB write.
- Debug write:
  - Honoured only in IDLE; ignored in other states.
  - In IDLE, dbg_we forces in_ready=0, so a debug write and an instruction accept never occur in the same cycle.
- dbg_rdata = regs[dbg_raddr] combinationally and reflects writes from the next cycle.
- in_valid while not ready: the instruction is not latched; the source must hold it.

Optional Feature:
- Macro EXEC_SEQ_SATURATE_EN.
- When defined, ADD and SUB saturate unsigned:
  - ADD overflow yields all-ones.
  - SUB underflow yields 0.
  - carry_flag still reports the overflow/borrow.
- When not defined, ADD and SUB wrap modulo 2**DATA_W.
- All other opcodes are identical in both builds.

Test Plan:
- Reset then idle: hold rst 2 cycles -> result=0, flags=0, done=0, all dbg_rdata=0, in_ready=0 during reset and 1 the cycle after.
- Debug load then ADD: dbg write r0=12'h005, r1=12'h003; issue ADD rd=r2 -> done 3 cycles after accept, result=12'h008, r2=12'h008, zero=0, carry=0.
- Wrap/saturate: r0=12'hFFF, r1=12'h001; ADD rd=r3 -> default build r3=12'h000, zero=1, carry=1; EXEC_SEQ_SATURATE_EN build r3=12'hFFF, carry=1.
- SUB borrow and SLT: r0=12'h003, r1=12'h005; SUB rd=r4 -> 12'hFFE, carry=1. r5=12'h800 (negative), r6=12'h001; SLT rd=r7 (rs1=r5, rs2=r6) -> 12'h001.
- Handshake stall: hold in_valid high across two instructions -> second accepted exactly 4 cycles after the first. dbg_we asserted in WB -> ignored. dbg_we in IDLE with in_valid -> in_ready=0, write done, instruction accepted next cycle.
- Reset mid-op: assert rst in EX of a MOV r1->r2 -> no done pulse, r2=0, FSM in IDLE after reset.
